// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray conversion function and ID width helper
package gray_pkg;

  localparam int GRAY_MAX_W = 64;

  // Zero-extended inputs convert correctly; callers truncate to their width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bin_gry.sv
// rtl/bin_gry.sv - combinational N-bit binary to Gray converter
module bin_gry
  import gray_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray = N'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

// File: rtl/gray_conv_arb.sv
// rtl/gray_conv_arb.sv - round-robin arbiter sharing one registered binary-to-Gray converter
module gray_conv_arb
  import gray_pkg::*;
#(
  parameter int  N    = 8,
  parameter int  NREQ = 4,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_bin,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_gray,
  output logic [N-1:0]      out_bin,
  output logic [ID_W-1:0]   out_id
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gid;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            load_ok;
  logic            xfer;
  logic [N-1:0]    sel_bin;
  logic [N-1:0]    conv_gray;
  int              idx;

  assign load_ok = ~out_valid | out_ready;

  // Search upward from rr_ptr, wrapping, first valid requester wins.
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gid        = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

  assign xfer      = found & load_ok & rst_n;
  assign req_ready = grant & {NREQ{load_ok & rst_n}};
  assign sel_bin   = req_bin[gid*N +: N];

  bin_gry #(.N(N)) u_bin_gry (
    .bin  (sel_bin),
    .gray (conv_gray)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_gray  <= '0;
      out_bin   <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_gray  <= conv_gray;
      out_bin   <= sel_bin;
      out_id    <= gid;
      rr_ptr    <= (gid == ID_W'(NREQ - 1)) ? '0 : gid + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_conv_arb.sv
// tb/tb_gray_conv_arb.sv - scoreboard bench for gray_conv_arb with a behavioural reference model
module tb_gray_conv_arb;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_bin;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_gray;
  logic [N-1:0]      out_bin;
  logic [ID_W-1:0]   out_id;

  gray_conv_arb #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic [N-1:0] b;
    int           id;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            m_ptr  = 0;
  bit            m_valid = 1'b0;
  logic [NREQ-1:0] acc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Gray bit i is the XOR of binary bits i and i+1 (bit N treated as 0).
  function automatic logic [N-1:0] ref_gray(input logic [N-1:0] b);
    logic [N:0] e;
    logic [N-1:0] g;
    e = {1'b0, b};
    for (int i = 0; i < N; i++) g[i] = e[i] ^ e[i+1];
    return g;
  endfunction

  // Reference model: predicts the handshake and pushes the expected result.
  always @(negedge clk) begin
    int g;
    bit lok;
    logic [NREQ-1:0] expr;
    logic [N-1:0] b;
    if (!rst_n) begin
      check("reset_req_ready", 64'(req_ready), 64'(0));
      m_valid = 1'b0;
      m_ptr   = 0;
      acc     = '0;
      sb.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      lok = !m_valid || out_ready;
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      expr = '0;
      if (g >= 0 && lok) expr[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(expr));
      acc = expr;
      if (expr != 0) begin
        b = req_bin[g*N +: N];
        sb.push_back('{ref_gray(b), b, g});
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NREQ;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: every output handshake consumes the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(0), 64'(1));
      end else begin
        e = sb.pop_front();
        check("sb_gray", 64'(out_gray), 64'(e.g));
        check("sb_bin", 64'(out_bin), 64'(e.b));
        check("sb_id", 64'(out_id), 64'(e.id));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int          rot_id[5];
    logic [N-1:0] rot_g[5];
    logic [N-1:0] bnd_w[3];
    logic [N-1:0] bnd_g[3];
    rot_id = '{0, 1, 2, 3, 0};
    rot_g  = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h01};
    bnd_w  = '{8'hFF, 8'h80, 8'h00};
    bnd_g  = '{8'h80, 8'hC0, 8'h00};

    rst_n = 1'b0; req_valid = '1; req_bin = '0; out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_gray", 64'(out_gray), 64'(0));
    check("rst_out_bin", 64'(out_bin), 64'(0));
    check("rst_out_id", 64'(out_id), 64'(0));
    step();

    // Single request
    rst_n = 1'b1; req_valid = 4'b0001; req_bin[0*N +: N] = 8'h05; out_ready = 1'b1;
    step();
    @(negedge clk);
    check("t1_valid", 64'(out_valid), 64'(1));
    check("t1_gray", 64'(out_gray), 64'h07);
    check("t1_bin", 64'(out_bin), 64'h05);
    check("t1_id", 64'(out_id), 64'(0));
    step();

    // Rotation with all requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) req_bin[i*N +: N] = N'(i + 1);
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      step();
      req_valid = '1;
      @(negedge clk);
      check("t2_id", 64'(out_id), 64'(rot_id[c]));
      check("t2_gray", 64'(out_gray), 64'(rot_g[c]));
    end
    step();
    req_valid = '0;
    step();

    // Backpressure
    do_reset();
    req_valid = 4'b0001; req_bin[0*N +: N] = 8'h05; out_ready = 1'b1;
    step();
    out_ready = 1'b0; req_valid = 4'b0100; req_bin[2*N +: N] = 8'h3C;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      check("t3_hold_gray", 64'(out_gray), 64'h07);
      check("t3_hold_ready", 64'(req_ready), 64'(0));
    end
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("t3_load_id", 64'(out_id), 64'(2));
    check("t3_load_gray", 64'(out_gray), 64'h22);

    // Boundary words from the highest-index requester
    for (int c = 0; c < 3; c++) begin
      step();
      req_valid = 4'b1000; req_bin[3*N +: N] = bnd_w[c];
      step();
      @(negedge clk);
      check("t4_gray", 64'(out_gray), 64'(bnd_g[c]));
      check("t4_id", 64'(out_id), 64'(3));
    end
    step();

    // Priority after wrap: pointer at 2, requesters 0 and 1 valid
    do_reset();
    req_valid = 4'b0010; req_bin[1*N +: N] = 8'h11;
    step();
    req_valid = 4'b0011; req_bin[0*N +: N] = 8'h20; req_bin[1*N +: N] = 8'h21;
    step();
    @(negedge clk);
    check("t5_first_id", 64'(out_id), 64'(0));
    step();
    @(negedge clk);
    check("t5_second_id", 64'(out_id), 64'(1));
    check("t5_second_gray", 64'(out_gray), 64'h31);
    step();

    // Reset mid-stream
    req_valid = 4'b0010; req_bin[1*N +: N] = 8'h40; out_ready = 1'b1;
    step();
    req_valid = 4'b0110; req_bin[1*N +: N] = 8'h41; req_bin[2*N +: N] = 8'h42; out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("t6_valid", 64'(out_valid), 64'(0));
    check("t6_gray", 64'(out_gray), 64'(0));
    check("t6_bin", 64'(out_bin), 64'(0));
    check("t6_id", 64'(out_id), 64'(0));
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    @(negedge clk);
    check("t6_ptr_reset_id", 64'(out_id), 64'(1));
    step();
    req_valid = '0;
    step();

    // Randomized traffic; requesters hold words until accepted
    do_reset();
    repeat (3000) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_bin[i*N +: N] = N'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    req_valid = '0; out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
